// File: rtl/axi_lite_delay_sram_pkg.sv
// Shared response codes and FSM state encodings for the trigger-delayed AXI4-Lite SRAM.
package axi_lite_delay_sram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    function automatic logic [1:0] resp_for(input logic hit);
        return hit ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi_lite_delay_sram_sram_array.sv
// Byte-lane storage: one registered read port and one byte-masked write port, no reset.
module sram_array #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be
);

    // One narrow array per byte lane keeps each lane a plain single-writer RAM;
    // a same-index read and write in one cycle returns the pre-write byte.
    for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_q_reg;

        always_ff @(posedge clk) begin
            if (wr_en && wr_be[gi]) begin
                lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
            end
            if (rd_en) begin
                lane_q_reg <= lane_mem[rd_idx];
            end
        end

        assign rd_data[gi*8 +: 8] = lane_q_reg;
    end

endmodule

// File: rtl/axi_lite_delay_sram.sv
// AXI4-Lite SRAM slave whose read and write responses are each released by the next delay_trigger pulse.
module axi_lite_delay_sram
    import axi_lite_delay_sram_pkg::*;
#(
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 1024,
    parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                delay_trigger,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4 * DEPTH);

    r_state_t              r_state_reg;
    logic                  arready_reg;
    logic                  rvalid_reg;
    logic [1:0]            rresp_reg;
    logic                  rdata_sel_reg;
    logic [ADDR_W-1:0]     raddr_reg;

    w_state_t              w_state_reg;
    logic                  awready_reg;
    logic                  wready_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;
    logic [ADDR_W-1:0]     waddr_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [DATA_W/8-1:0]   wstrb_reg;

    logic [ADDR_W-1:0]     dec_addr [2];
    logic                  dec_hit  [2];
    logic [IDX_W-1:0]      dec_idx  [2];

    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [DATA_W-1:0]     mem_rd_data;

    // Port 0 decodes the latched read address, port 1 the latched write address.
    assign dec_addr[0] = raddr_reg;
    assign dec_addr[1] = waddr_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_decode
        logic [ADDR_W-1:0] offset;
        assign offset       = dec_addr[gi] - BASE;
        assign dec_hit[gi]  = (dec_addr[gi] >= BASE) && (offset < SPAN);
        assign dec_idx[gi]  = offset[IDX_W+1:2];
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_reg   <= R_IDLE;
            arready_reg   <= 1'b1;
            rvalid_reg    <= 1'b0;
            rresp_reg     <= RESP_OKAY;
            rdata_sel_reg <= 1'b0;
            raddr_reg     <= '0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (arvalid && arready_reg) begin
                        raddr_reg   <= araddr;
                        arready_reg <= 1'b0;
                        r_state_reg <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (delay_trigger) begin
                        rresp_reg     <= resp_for(dec_hit[0]);
                        rdata_sel_reg <= dec_hit[0];
                        rvalid_reg    <= 1'b1;
                        r_state_reg   <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid_reg  <= 1'b0;
                        arready_reg <= 1'b1;
                        r_state_reg <= R_IDLE;
                    end
                end
                default: begin
                    r_state_reg <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write FSM: AW and W are latched independently while idle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_reg <= W_IDLE;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (awvalid && awready_reg) begin
                        waddr_reg   <= awaddr;
                        awready_reg <= 1'b0;
                    end
                    if (wvalid && wready_reg) begin
                        wdata_reg  <= wdata;
                        wstrb_reg  <= wstrb;
                        wready_reg <= 1'b0;
                    end
                    // A dropped ready means that beat is already held.
                    if ((!awready_reg || awvalid) && (!wready_reg || wvalid)) begin
                        w_state_reg <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (delay_trigger) begin
                        bresp_reg   <= resp_for(dec_hit[1]);
                        bvalid_reg  <= 1'b1;
                        w_state_reg <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_reg  <= 1'b0;
                        awready_reg <= 1'b1;
                        wready_reg  <= 1'b1;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: begin
                    w_state_reg <= W_IDLE;
                end
            endcase
        end
    end

    // Storage is touched only in the trigger cycle, and only for in-range addresses.
    assign mem_rd_en = (r_state_reg == R_WAIT) && delay_trigger && dec_hit[0];
    assign mem_wr_en = (w_state_reg == W_WAIT) && delay_trigger && dec_hit[1];

    sram_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_sram_array (
        .clk     (clk),
        .rd_en   (mem_rd_en),
        .rd_idx  (dec_idx[0]),
        .rd_data (mem_rd_data),
        .wr_en   (mem_wr_en),
        .wr_idx  (dec_idx[1]),
        .wr_data (wdata_reg),
        .wr_be   (wstrb_reg)
    );

    // The RAM output register has no reset, so gate it until an in-range read lands.
    assign rdata   = rdata_sel_reg ? mem_rd_data : '0;
    assign rresp   = rresp_reg;
    assign rvalid  = rvalid_reg;
    assign arready = arready_reg;
    assign awready = awready_reg;
    assign wready  = wready_reg;
    assign bvalid  = bvalid_reg;
    assign bresp   = bresp_reg;

endmodule

// File: tb/tb_axi_lite_delay_sram.sv
// Self-checking bench for axi_lite_delay_sram: vector table, corner sequences, randomized traffic vs a word-map model.
module tb_axi_lite_delay_sram;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          BOUND = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        delay_trigger = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [int];

    axi_lite_delay_sram #(
        .ADDR_W (32),
        .DATA_W (32),
        .DEPTH  (DEPTH),
        .BASE   (BASE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .delay_trigger (delay_trigger),
        .araddr        (araddr),
        .arvalid       (arvalid),
        .arready       (arready),
        .rdata         (rdata),
        .rresp         (rresp),
        .rvalid        (rvalid),
        .rready        (rready),
        .awaddr        (awaddr),
        .awvalid       (awvalid),
        .awready       (awready),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .wvalid        (wvalid),
        .wready        (wready),
        .bresp         (bresp),
        .bvalid        (bvalid),
        .bready        (bready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit in_map(input logic [31:0] a);
        logic [63:0] a64;
        logic [63:0] lo;
        a64 = {32'd0, a};
        lo  = {32'd0, BASE};
        return (a64 >= lo) && (a64 < lo + 64'(4 * DEPTH));
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!in_map(a)) return 32'h0;
        if (!model.exists(word_of(a))) return 32'hxxxx_xxxx;
        return model[word_of(a)];
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        return in_map(a) ? 2'b00 : 2'b10;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] cur;
        if (!in_map(a)) return;
        cur = model.exists(word_of(a)) ? model[word_of(a)] : 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) cur[b*8 +: 8] = d[b*8 +: 8];
        end
        model[word_of(a)] = cur;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string what);
        checks++;
        errors++;
        $display("FAIL timeout_%s: no handshake within %0d cycles", what, BOUND);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        araddr  = a;
        arvalid = 1'b1;
        while (!arready && n < BOUND) begin step(); n++; end
        if (n == BOUND) fail_timeout("ar");
        step();
        arvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        awaddr  = a;
        awvalid = 1'b1;
        while (!awready && n < BOUND) begin step(); n++; end
        if (n == BOUND) fail_timeout("aw");
        step();
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        while (!wready && n < BOUND) begin step(); n++; end
        if (n == BOUND) fail_timeout("w");
        step();
        wvalid = 1'b0;
    endtask

    task automatic get_r(output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        while (!rvalid && n < BOUND) begin step(); n++; end
        if (n == BOUND) fail_timeout("r");
        rready = 1'b1;
        d = rdata;
        r = rresp;
        step();
        rready = 1'b0;
    endtask

    task automatic get_b(output logic [1:0] r);
        int n = 0;
        while (!bvalid && n < BOUND) begin step(); n++; end
        if (n == BOUND) fail_timeout("b");
        bready = 1'b1;
        r = bresp;
        step();
        bready = 1'b0;
    endtask

    task automatic pulse();
        delay_trigger = 1'b1;
        step();
        delay_trigger = 1'b0;
    endtask

    task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int pre_aw, input int pre_w, input int dly, output logic [1:0] r);
        fork
            begin repeat (pre_aw) step(); send_aw(a); end
            begin repeat (pre_w) step(); send_w(d, s); end
        join
        repeat (dly) step();
        pulse();
        chk("bvalid_latency", 32'(bvalid), 32'd1);
        get_b(r);
        $display("WR addr=%h data=%h strb=%b dly=%0d bresp=%0d", a, d, s, dly, r);
    endtask

    task automatic read_txn(input logic [31:0] a, input int dly, output logic [31:0] d, output logic [1:0] r);
        send_ar(a);
        repeat (dly) step();
        pulse();
        chk("rvalid_latency", 32'(rvalid), 32'd1);
        get_r(d, r);
        $display("RD addr=%h dly=%0d rdata=%h rresp=%0d", a, dly, d, r);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          do_wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  exp_b;
        logic [31:0] raddr;
        logic [31:0] exp_rd;
        logic [1:0]  exp_rr;
        int          dly;
    } vec_t;

    function automatic vec_t mk(input bit w, input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] s,
                                input logic [1:0] eb, input logic [31:0] ra, input logic [31:0] er,
                                input logic [1:0] err, input int dly);
        vec_t v;
        v.do_wr = w;  v.waddr = wa; v.wdata = wd; v.strb = s; v.exp_b = eb;
        v.raddr = ra; v.exp_rd = er; v.exp_rr = err; v.dly = dly;
        return v;
    endfunction

    vec_t vecs [10];

    initial begin
        logic [31:0] d, d0, old_v, new_v, a;
        logic [1:0]  r, rb;
        bit          bad;
        int          idx;

        vecs[0] = mk(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF,    2'b00, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0);
        vecs[1] = mk(1, 32'h8000_0020, 32'h1122_3344, 4'hF,    2'b00, 32'h8000_0020, 32'h1122_3344, 2'b00, 2);
        vecs[2] = mk(1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 2'b00, 32'h8000_0020, 32'h11BB_33DD, 2'b00, 1);
        vecs[3] = mk(1, 32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, 2'b00, 32'h8000_0020, 32'h11BB_33DD, 2'b00, 3);
        vecs[4] = mk(1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF,    2'b00, 32'h8000_0000, 32'hCAFE_F00D, 2'b00, 0);
        vecs[5] = mk(1, 32'h8000_1000, 32'h1234_5678, 4'hF,    2'b10, 32'h8000_1000, 32'h0000_0000, 2'b10, 1);
        vecs[6] = mk(0, 32'h0,         32'h0,         4'h0,    2'b00, 32'h7FFF_FFFC, 32'h0000_0000, 2'b10, 4);
        vecs[7] = mk(0, 32'h0,         32'h0,         4'h0,    2'b00, 32'h8000_0000, 32'hCAFE_F00D, 2'b00, 0);
        vecs[8] = mk(1, 32'h8000_0FFF, 32'h0BAD_C0DE, 4'hF,    2'b00, 32'h8000_0FFC, 32'h0BAD_C0DE, 2'b00, 2);
        vecs[9] = mk(1, 32'hFFFF_FFFC, 32'h5555_AAAA, 4'hF,    2'b10, 32'hFFFF_FFFC, 32'h0000_0000, 2'b10, 1);

        // Reset values, sampled while reset is held.
        step(); step();
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_awready", 32'(awready), 32'd1);
        chk("rst_wready",  32'(wready),  32'd1);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        chk("rst_rdata",   rdata,        32'd0);
        chk("rst_rresp",   32'(rresp),   32'd0);
        chk("rst_bresp",   32'(bresp),   32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr) begin
                write_txn(vecs[i].waddr, vecs[i].wdata, vecs[i].strb, 0, i % 3, vecs[i].dly, rb);
                chk($sformatf("vec%0d_bresp", i), 32'(rb), 32'(vecs[i].exp_b));
                model_write(vecs[i].waddr, vecs[i].wdata, vecs[i].strb);
            end
            read_txn(vecs[i].raddr, vecs[i].dly, d, r);
            chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rd);
            chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].exp_rr));
        end

        // Randomized traffic: initialise the address pool, then mixed reads/writes.
        for (int i = 0; i < 20; i++) begin
            idx = (i < 16) ? i : 1004 + i;
            a = BASE + 32'(idx * 4);
            d = $urandom;
            write_txn(a, d, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), rb);
            chk("init_bresp", 32'(rb), 32'd0);
            model_write(a, d, 4'hF);
        end
        for (int i = 0; i < 150; i++) begin
            idx = $urandom_range(0, 19);
            idx = (idx < 16) ? idx : 1004 + idx;
            a = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0:       a = BASE - 32'd4;
                    1:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255) * 4);
                    2:       a = 32'h0000_0000 + 32'($urandom_range(0, 1023) * 4);
                    default: a = 32'hC000_0000;
                endcase
            end
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                write_txn(a, d, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 4), rb);
                chk("rnd_bresp", 32'(rb), 32'(model_resp(a)));
                model_write(a, d, wstrb);
            end else begin
                read_txn(a, $urandom_range(0, 4), d, r);
                chk("rnd_rdata", d, model_read(a));
                chk("rnd_rresp", 32'(r), 32'(model_resp(a)));
            end
        end

        // Trigger coinciding with the AR handshake must not release the read.
        delay_trigger = 1'b1;
        send_ar(32'h8000_0004);
        delay_trigger = 1'b0;
        step();
        chk("hs_trigger_ignored", 32'(rvalid), 32'd0);
        pulse();
        chk("hs_trigger_then_valid", 32'(rvalid), 32'd1);
        get_r(d, r);
        chk("hs_trigger_rdata", d, model_read(32'h8000_0004));

        // Long delay with rvalid held against rready=0.
        send_ar(32'h8000_0010);
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (rvalid) bad = 1'b1;
        end
        chk("delay_no_early_rvalid", 32'(bad), 32'd0);
        pulse();
        chk("delay_rvalid_after_pulse", 32'(rvalid), 32'd1);
        d0 = rdata;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (!rvalid || rdata !== d0) bad = 1'b1;
        end
        chk("delay_rvalid_hold_stable", 32'(bad), 32'd0);
        get_r(d, r);
        chk("delay_rdata", d, model_read(32'h8000_0010));
        $display("RD addr=80000010 dly=20 rdata=%h rresp=%0d", d, r);

        // W three cycles ahead of AW; one pulse releases a same-address read and the write.
        a = 32'h8000_0030;
        old_v = model_read(a);
        new_v = ~old_v ^ 32'h0F0F_0000;
        send_w(new_v, 4'hF);
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!awready || wready) bad = 1'b1;
            step();
        end
        chk("w_first_readys", 32'(bad), 32'd0);
        send_aw(a);
        send_ar(a);
        pulse();
        chk("shared_rvalid", 32'(rvalid), 32'd1);
        chk("shared_bvalid", 32'(bvalid), 32'd1);
        get_r(d, r);
        chk("shared_read_old", d, old_v);
        get_b(rb);
        chk("shared_bresp", 32'(rb), 32'd0);
        model_write(a, new_v, 4'hF);
        $display("RW addr=%h old=%h new=%h rdata=%h bresp=%0d", a, old_v, new_v, d, rb);
        read_txn(a, 1, d, r);
        chk("shared_read_new", d, new_v);

        // Reset while both FSMs are waiting for a trigger.
        a = 32'h8000_0034;
        old_v = model_read(a);
        send_ar(a);
        fork
            send_aw(a);
            send_w(~old_v, 4'hF);
        join
        #2 rst = 1'b0;
        #1;
        chk("midrst_rvalid",  32'(rvalid),  32'd0);
        chk("midrst_bvalid",  32'(bvalid),  32'd0);
        chk("midrst_arready", 32'(arready), 32'd1);
        chk("midrst_awready", 32'(awready), 32'd1);
        chk("midrst_wready",  32'(wready),  32'd1);
        @(negedge clk);
        rst = 1'b1;
        step();
        pulse();
        step();
        chk("postrst_no_resp", 32'({rvalid, bvalid}), 32'd0);
        read_txn(a, 0, d, r);
        chk("postrst_word_unchanged", d, old_v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
